crt_sync_generator: RTL and testbench

Generates VGA horizontal/vertical sync, active-video flag and current pixel coordinates for the Pong display. Consumes the `PixelClock` square wave produced by the CRT clock divider. Runs entirely in the system `Clock` domain: `PixelClock` is treated as a data level, and each rising edge is one pixel tick. Outputs feed the VGA connector pins and the paddle/ball/score pixel renderers.

---
 rtl/crt_timing_pkg.sv | 26 ++
 rtl/crt_axis_counter.sv | 72 +++++++
 rtl/crt_sync_generator.sv | 86 ++++++++
 tb/tb_crt_sync_generator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crt_timing_pkg.sv
// crt_timing_pkg: 640x480@60 timing constants and the per-axis phase enum
// shared by the CRT sync generator and its axis counters.
package crt_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int COUNT_SIZE = 10;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

endpackage

// File: rtl/crt_axis_counter.sv
// crt_axis_counter: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
// for one display axis; Phase is the phase of the position after this edge.
module crt_axis_counter
  import crt_timing_pkg::*;
#(
  parameter int Active    = H_ACTIVE,
  parameter int Front     = H_FRONT,
  parameter int SyncW     = H_SYNC,
  parameter int Back      = H_BACK,
  parameter int CountSize = COUNT_SIZE
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Advance,
  output logic [CountSize-1:0] Count,
  output phase_t               Phase,
  output logic                 Wrap
);

  localparam int Total = Active + Front + SyncW + Back;

  localparam logic [CountSize-1:0] LastAct =
    CountSize'(Active - 1);
  localparam logic [CountSize-1:0] LastFront =
    CountSize'(Active + Front - 1);
  localparam logic [CountSize-1:0] LastSync =
    CountSize'(Active + Front + SyncW - 1);
  localparam logic [CountSize-1:0] LastTot =
    CountSize'(Total - 1);
  localparam logic [CountSize-1:0] One =
    CountSize'(1);

  logic [CountSize-1:0] r_count;
  logic [CountSize-1:0] w_count_nxt;
  phase_t               r_phase;
  phase_t               w_phase_nxt;
  logic                 w_at_end;

  assign w_at_end = (r_count == LastTot);
  assign Wrap     = Advance & w_at_end;
  assign Count    = r_count;
  assign Phase    = w_phase_nxt;

  always_comb begin
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    if (Advance) begin
      w_count_nxt = w_at_end ? '0 : r_count + One;
      unique case (r_phase)
        PH_ACTIVE:
          if (r_count == LastAct)   w_phase_nxt = PH_FRONT;
        PH_FRONT:
          if (r_count == LastFront) w_phase_nxt = PH_SYNC;
        PH_SYNC:
          if (r_count == LastSync)  w_phase_nxt = PH_BACK;
        PH_BACK:
          if (w_at_end)             w_phase_nxt = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= LastTot;
      r_phase <= PH_BACK;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

endmodule

// File: rtl/crt_sync_generator.sv
// crt_sync_generator: VGA sync/position generator clocked by Clock,
// advancing one pixel per rising edge of the PixelClock level.
module crt_sync_generator
  import crt_timing_pkg::*;
#(
  parameter int HActive   = H_ACTIVE,
  parameter int HFront    = H_FRONT,
  parameter int HSyncW    = H_SYNC,
  parameter int HBack     = H_BACK,
  parameter int VActive   = V_ACTIVE,
  parameter int VFront    = V_FRONT,
  parameter int VSyncW    = V_SYNC,
  parameter int VBack     = V_BACK,
  parameter int CountSize = COUNT_SIZE
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 PixelClock,
  output logic                 HSync,
  output logic                 VSync,
  output logic                 VideoOn,
  output logic [CountSize-1:0] PixelX,
  output logic [CountSize-1:0] PixelY,
  output logic                 FrameStart
);

  logic   r_pixel_prev;
  logic   w_tick;
  logic   w_h_wrap;
  logic   w_v_adv;
  logic   w_v_wrap;
  phase_t w_h_phase;
  phase_t w_v_phase;

  assign w_tick  = PixelClock & ~r_pixel_prev;
  assign w_v_adv = w_tick & w_h_wrap;

  crt_axis_counter #(
    .Active    (HActive),
    .Front     (HFront),
    .SyncW     (HSyncW),
    .Back      (HBack),
    .CountSize (CountSize)
  ) u_h (
    .Clock   (Clock),
    .Reset   (Reset),
    .Advance (w_tick),
    .Count   (PixelX),
    .Phase   (w_h_phase),
    .Wrap    (w_h_wrap)
  );

  crt_axis_counter #(
    .Active    (VActive),
    .Front     (VFront),
    .SyncW     (VSyncW),
    .Back      (VBack),
    .CountSize (CountSize)
  ) u_v (
    .Clock   (Clock),
    .Reset   (Reset),
    .Advance (w_v_adv),
    .Count   (PixelY),
    .Phase   (w_v_phase),
    .Wrap    (w_v_wrap)
  );

  // Phases are next-state, so these flags land with PixelX/PixelY.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pixel_prev <= 1'b0;
      HSync        <= 1'b1;
      VSync        <= 1'b1;
      VideoOn      <= 1'b0;
      FrameStart   <= 1'b0;
    end else begin
      r_pixel_prev <= PixelClock;
      HSync        <= (w_h_phase != PH_SYNC);
      VSync        <= (w_v_phase != PH_SYNC);
      VideoOn      <= (w_h_phase == PH_ACTIVE) &&
                      (w_v_phase == PH_ACTIVE);
      FrameStart   <= w_v_wrap;
    end
  end

endmodule

// File: tb/tb_crt_sync_generator.sv
// tb_crt_sync_generator: directed vectors on the 640x480 instance plus a
// tiny-timing instance that exercises whole frames and the corner wrap.
module tb_crt_sync_generator;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       PixelClock = 1'b0;
  logic       HSync, VSync, VideoOn, FrameStart;
  logic [9:0] PixelX, PixelY;
  logic       s_hs, s_vs, s_vo, s_fs;
  logic [9:0] s_x, s_y;

  always #5 Clock = ~Clock;

  crt_sync_generator u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .PixelClock (PixelClock),
    .HSync      (HSync),
    .VSync      (VSync),
    .VideoOn    (VideoOn),
    .PixelX     (PixelX),
    .PixelY     (PixelY),
    .FrameStart (FrameStart)
  );

  // 15 x 8 positions: x sync 10..12, y sync 5..6, active 8 x 4
  crt_sync_generator #(
    .HActive(8), .HFront(2), .HSyncW(3), .HBack(2),
    .VActive(4), .VFront(1), .VSyncW(2), .VBack(1),
    .CountSize(10)
  ) u_small (
    .Clock      (Clock),
    .Reset      (Reset),
    .PixelClock (PixelClock),
    .HSync      (s_hs),
    .VSync      (s_vs),
    .VideoOn    (s_vo),
    .PixelX     (s_x),
    .PixelY     (s_y),
    .FrameStart (s_fs)
  );

  typedef struct packed {
    logic       rst;
    logic       pc;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       fs;
  } vec_t;

  vec_t tbl [10];

  int n_cmp = 0;
  int n_bad = 0;

  logic prev_pc = 1'b0;
  int   cyc = 0;
  int   ntick = 0;
  int   sm_x = 14;
  int   sm_y = 7;
  int   last_x = 799;
  int   wrap_q [$];
  int   hs_low_y1 = 0;
  int   bad_hs = 0, bad_vs = 0, bad_vo = 0;
  int   bad_rng = 0, bad_fs = 0;
  int   s_bad_hs = 0, s_bad_vs = 0, s_bad_vo = 0;
  int   s_bad_pos = 0, s_bad_fs = 0, s_nfs = 0;
  int   s_last_fs = -1;
  int   s_vs_low = 0;
  int   q_sframe [$];
  int   q_svs [$];
  int   bad_hold = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input logic rst, input logic tk);
    logic e;
    e = !(PixelX >= 656 && PixelX <= 751);
    if (HSync !== e) bad_hs++;
    e = !(PixelY >= 490 && PixelY <= 491);
    if (VSync !== e) bad_vs++;
    e = (PixelX < 640) && (PixelY < 480);
    if (VideoOn !== e) bad_vo++;
    if (PixelX > 799 || PixelY > 524) bad_rng++;
    if (FrameStart === 1'b1 && (PixelX != 0 || PixelY != 0))
      bad_fs++;
    if (PixelX == 0 && last_x == 799) wrap_q.push_back(cyc);
    last_x = int'(PixelX);
    if (PixelY == 1 && HSync === 1'b0) hs_low_y1++;

    e = !(s_x >= 10 && s_x <= 12);
    if (s_hs !== e) s_bad_hs++;
    e = !(s_y >= 5 && s_y <= 6);
    if (s_vs !== e) s_bad_vs++;
    e = (s_x < 8) && (s_y < 4);
    if (s_vo !== e) s_bad_vo++;
    if (int'(s_x) != sm_x || int'(s_y) != sm_y) s_bad_pos++;
    e = rst && tk && sm_x == 0 && sm_y == 0;
    if (s_fs !== e) s_bad_fs++;
    if (!rst) begin
      s_last_fs = -1;
      s_vs_low  = 0;
    end else begin
      if (tk && s_vs === 1'b0) s_vs_low++;
      if (s_fs === 1'b1) begin
        s_nfs++;
        if (s_last_fs >= 0) begin
          q_sframe.push_back(ntick - s_last_fs);
          q_svs.push_back(s_vs_low);
        end
        s_last_fs = ntick;
        s_vs_low  = 0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic pc);
    logic tk;
    @(negedge Clock);
    Reset = rst;
    PixelClock = pc;
    @(posedge Clock);
    #1;
    cyc++;
    tk = rst && pc && !prev_pc;
    prev_pc = rst ? pc : 1'b0;
    if (!rst) begin
      sm_x = 14;
      sm_y = 7;
    end else if (tk) begin
      ntick++;
      if (sm_x == 14) begin
        sm_x = 0;
        sm_y = (sm_y == 7) ? 0 : sm_y + 1;
      end else begin
        sm_x++;
      end
    end
    sample(rst, tk);
  endtask

  task automatic tick4(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].pc);
      chk($sformatf("v%0d_x", i), PixelX, tbl[i].x);
      chk($sformatf("v%0d_y", i), PixelY, tbl[i].y);
      chk($sformatf("v%0d_hs", i), HSync, tbl[i].hs);
      chk($sformatf("v%0d_vs", i), VSync, tbl[i].vs);
      chk($sformatf("v%0d_vo", i), VideoOn, tbl[i].vo);
      chk($sformatf("v%0d_fs", i), FrameStart, tbl[i].fs);
    end

    tick4(799);
    chk("line1_x", PixelX, 0);
    chk("line1_y", PixelY, 1);
    chk("line1_fs", FrameStart, 0);

    tick4(800);
    chk("line2_x", PixelX, 0);
    chk("line2_y", PixelY, 2);
    chk("hs_low_cycles", hs_low_y1, 384);
    if (wrap_q.size() >= 2)
      chk("line_period",
          wrap_q[wrap_q.size()-1] - wrap_q[wrap_q.size()-2], 3200);
    else
      chk("line_wraps_seen", wrap_q.size(), 2);

    tick4(299);
    step(1'b1, 1'b1);
    chk("freeze_x", PixelX, 300);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1);
      if (PixelX != 300 || PixelY != 2 || HSync !== 1'b1 ||
          VSync !== 1'b1 || VideoOn !== 1'b1 ||
          FrameStart !== 1'b0)
        bad_hold++;
    end
    chk("freeze_hold", bad_hold, 0);
    step(1'b1, 1'b0);
    chk("freeze_low_x", PixelX, 300);
    step(1'b1, 1'b1);
    chk("resume_x", PixelX, 301);

    @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_x", PixelX, 799);
    chk("arst_y", PixelY, 524);
    chk("arst_hs", HSync, 1);
    chk("arst_vs", VSync, 1);
    chk("arst_vo", VideoOn, 0);
    chk("arst_fs", FrameStart, 0);
    chk("arst_small_x", s_x, 14);
    prev_pc = 1'b0;
    sm_x = 14;
    sm_y = 7;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("restart_x", PixelX, 0);
    chk("restart_y", PixelY, 0);
    chk("restart_vo", VideoOn, 1);
    chk("restart_fs", FrameStart, 1);
    step(1'b1, 1'b1);
    chk("restart_fs_off", FrameStart, 0);

    chk("inv_hsync", bad_hs, 0);
    chk("inv_vsync", bad_vs, 0);
    chk("inv_videoon", bad_vo, 0);
    chk("inv_range", bad_rng, 0);
    chk("inv_framestart", bad_fs, 0);
    chk("small_hsync", s_bad_hs, 0);
    chk("small_vsync", s_bad_vs, 0);
    chk("small_videoon", s_bad_vo, 0);
    chk("small_position", s_bad_pos, 0);
    chk("small_framestart", s_bad_fs, 0);
    chk("small_frames_seen", q_sframe.size() >= 5, 1);
    for (int i = 0; i < q_sframe.size() && i < 4; i++) begin
      chk($sformatf("small_frame%0d_ticks", i), q_sframe[i], 120);
      chk($sformatf("small_frame%0d_vsync", i), q_svs[i], 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
